mem_access_stage: RTL

MEM stage of the 5-stage MIPS32 pipeline: sits between the EX/MEM pipeline register (fed by the EX stage's ALU result and forwarded store operand) and the WB stage. It runs word loads and stores against a data memory with variable latency over a req/ready handshake. It stalls the upstream pipeline while an access is outstanding and aborts accesses that are misaligned or time out. It registers the MEM/WB results, including the write-back value used by the EX-stage forwarding muxes.

---
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_stage
//  Description : MEM stage of a 5-stage MIPS32 pipeline. Issues word loads and
//                stores to a variable-latency data memory over a req/ready
//                handshake, stalls upstream while an access is outstanding,
//                aborts misaligned or timed-out accesses, and registers the
//                MEM/WB results (including the forwarded write-back value).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset               : pipeline clock, asynchronous active-low reset
//    ex_mem_*                 : EX/MEM pipeline register contents
//    dmem_req/we/addr/wdata   : data memory request (addr/we/wdata 0 when idle)
//    dmem_ready/rdata         : data memory completion and load data
//    mem_stall                : freeze PC, IF/ID, ID/EX, EX/MEM this cycle
//    mem_wb_*                 : registered MEM/WB outputs
//    mem_misaligned           : one-cycle pulse after a misaligned access
//    mem_bus_error            : one-cycle pulse after an access timeout
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_mem_to_reg,
    input  logic        ex_mem_reg_write,
    input  logic [4:0]  ex_mem_dest_reg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_dest_reg,
    output logic [31:0] mem_wb_write_back_result,
    output logic        mem_misaligned,
    output logic        mem_bus_error
);

    localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // FSM and request latches
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      addr_q,  addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q,    we_d;
    // Write-back attributes of the outstanding op, so WAIT never looks at
    // the EX/MEM inputs.
    logic             m2r_q,   m2r_d;
    logic             rw_q,    rw_d;
    logic [4:0]       dest_q,  dest_d;

    // MEM/WB register
    logic             wb_valid_q, wb_valid_d;
    logic             wb_rw_q,    wb_rw_d;
    logic [4:0]       wb_dest_q,  wb_dest_d;
    logic [31:0]      wb_res_q,   wb_res_d;
    logic             misal_q,    buserr_q;

    logic        w_op, w_aligned;
    logic        w_req, w_we, w_stall, w_abort, w_misalign;
    logic [31:0] w_addr, w_wdata;

    assign w_op      = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
    assign w_aligned = (ex_mem_alu_result[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        dest_d     = dest_q;
        w_req      = 1'b0;
        w_we       = 1'b0;
        w_addr     = 32'd0;
        w_wdata    = 32'd0;
        w_stall    = 1'b0;
        w_abort    = 1'b0;
        w_misalign = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_op && w_aligned) begin
                    w_req   = 1'b1;
                    w_we    = ex_mem_mem_write;   // write wins over read
                    w_addr  = ex_mem_alu_result;
                    w_wdata = ex_mem_store_data;
                    if (!dmem_ready) begin
                        w_stall = 1'b1;
                        state_d = S_WAIT;
                        count_d = C_ONE;
                        addr_d  = ex_mem_alu_result;
                        wdata_d = ex_mem_store_data;
                        we_d    = ex_mem_mem_write;
                        m2r_d   = ex_mem_mem_to_reg;
                        rw_d    = ex_mem_reg_write;
                        dest_d  = ex_mem_dest_reg;
                    end
                end else if (w_op) begin
                    w_misalign = 1'b1;
                end
            end
            S_WAIT: begin
                w_req   = 1'b1;
                w_we    = we_q;
                w_addr  = addr_q;
                w_wdata = wdata_q;
                if (dmem_ready) begin
                    // Completion wins even in the timeout cycle.
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (count_q == C_LAST) begin
                    w_abort = 1'b1;
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    w_stall = 1'b1;
                    count_d = count_q + C_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // MEM/WB next state: bubble on stall/abort/misalign, otherwise capture
    // either the completing WAIT op (latched) or the current EX/MEM contents.
    always_comb begin
        wb_valid_d = 1'b0;
        wb_rw_d    = 1'b0;
        wb_dest_d  = wb_dest_q;
        wb_res_d   = wb_res_q;
        if (!(w_stall || w_abort || w_misalign)) begin
            if (state_q == S_WAIT) begin
                wb_valid_d = 1'b1;
                wb_rw_d    = rw_q;
                wb_dest_d  = dest_q;
                wb_res_d   = m2r_q ? dmem_rdata : addr_q;
            end else begin
                wb_valid_d = ex_mem_valid;
                wb_rw_d    = ex_mem_valid & ex_mem_reg_write;
                wb_dest_d  = ex_mem_dest_reg;
                wb_res_d   = ex_mem_mem_to_reg ? dmem_rdata : ex_mem_alu_result;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            we_q       <= 1'b0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            dest_q     <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_dest_q  <= 5'd0;
            wb_res_q   <= 32'd0;
            misal_q    <= 1'b0;
            buserr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            dest_q     <= dest_d;
            wb_valid_q <= wb_valid_d;
            wb_rw_q    <= wb_rw_d;
            wb_dest_q  <= wb_dest_d;
            wb_res_q   <= wb_res_d;
            misal_q    <= w_misalign;
            buserr_q   <= w_abort;
        end
    end

    // The request and stall are gated by reset so they drop immediately,
    // even while upstream is still presenting a memory op.
    assign dmem_req   = w_req & reset;
    assign dmem_we    = w_we & reset;
    assign dmem_addr  = reset ? w_addr  : 32'd0;
    assign dmem_wdata = reset ? w_wdata : 32'd0;
    assign mem_stall  = w_stall & reset;

    assign mem_wb_valid             = wb_valid_q;
    assign mem_wb_reg_write         = wb_rw_q;
    assign mem_wb_dest_reg          = wb_dest_q;
    assign mem_wb_write_back_result = wb_res_q;
    assign mem_misaligned           = misal_q;
    assign mem_bus_error            = buserr_q;

endmodule
`default_nettype wire
